// File: rtl/ck_square_acc_stage.sv
// One LABS energy stage: C_k = L - 2*popcount(a^b), acc_out = acc_in + C_k^2.
// Define CK_SQACC_SATURATE_EN to saturate the accumulator instead of wrapping.
module ck_square_acc_stage #(
  parameter int SEQ_WIDTH   = 8,
  parameter int STAGE_WIDTH = 20,
  parameter int E_WIDTH     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEQ_WIDTH-1:0] a,
  input  logic [SEQ_WIDTH-1:0] b,
  output logic [7:0]           ck,
  input  logic [E_WIDTH-1:0]   acc_in,
  output logic [E_WIDTH-1:0]   acc_out
);

  localparam int unsigned NCHUNK = (SEQ_WIDTH + STAGE_WIDTH - 1) / STAGE_WIDTH;
  localparam int unsigned PW     = NCHUNK * STAGE_WIDTH;
  localparam int unsigned CW     = $clog2(STAGE_WIDTH + 1);

  logic [PW-1:0]                diff;
  logic [NCHUNK-1:0][CW-1:0]    cnt_c;
  logic [NCHUNK-1:0][CW-1:0]    cnt_r;
  logic [7:0]                   m;
  logic [7:0]                   ck_c;
  logic signed [7:0]            ck_s;
  logic signed [15:0]           sq;
  logic [E_WIDTH-1:0]           acc_c;

  // Zero-padding the last chunk keeps every chunk loop the same length.
  always_comb begin
    diff = PW'(a ^ b);
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      cnt_c[c] = '0;
      for (int unsigned i = 0; i < STAGE_WIDTH; i++)
        cnt_c[c] = cnt_c[c] + CW'(diff[c*STAGE_WIDTH + i]);
    end
  end

  always_comb begin
    m = '0;
    for (int unsigned c = 0; c < NCHUNK; c++)
      m = m + 8'(cnt_r[c]);
    ck_c = 8'(SEQ_WIDTH) - (m << 1);
  end

  always_comb begin
    ck_s = ck;
    sq   = ck_s * ck_s;
  end

`ifdef CK_SQACC_SATURATE_EN
  localparam int unsigned SW = ((E_WIDTH > 16) ? E_WIDTH : 16) + 1;
  logic [SW-1:0] sum;

  always_comb begin
    sum   = SW'(acc_in) + SW'($unsigned(sq));
    acc_c = (|sum[SW-1:E_WIDTH]) ? '1 : sum[E_WIDTH-1:0];
  end
`else
  always_comb begin
    acc_c = acc_in + E_WIDTH'($unsigned(sq));
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= '0;
      ck      <= '0;
      acc_out <= '0;
    end else begin
      cnt_r   <= cnt_c;
      ck      <= ck_c;
      acc_out <= acc_c;
    end
  end

endmodule

// File: tb/tb_ck_square_acc_stage.sv
// Directed + streamed checks of ck_square_acc_stage at (L=8, chunk 20) and (L=13, chunk 3).
module tb_ck_square_acc_stage;

  localparam int ND = 8;
  localparam int NT = ND + 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, ck8;
  logic [19:0] acc8_in = '0, acc8_out;
  logic [12:0] a13 = '0, b13 = '0;
  logic [7:0]  ck13;
  logic [19:0] acc13_in = '0, acc13_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  va8 [NT], vb8 [NT], eck8 [NT], eck13 [NT];
  logic [12:0] va13[NT], vb13[NT];
  logic [19:0] vacc8[NT], eacc8[NT], vacc13[NT], eacc13[NT];

  always #5 clk = ~clk;

  ck_square_acc_stage #(.SEQ_WIDTH(8), .STAGE_WIDTH(20), .E_WIDTH(20)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .ck(ck8), .acc_in(acc8_in), .acc_out(acc8_out));

  ck_square_acc_stage #(.SEQ_WIDTH(13), .STAGE_WIDTH(3), .E_WIDTH(20)) dut13 (
    .clk(clk), .rst(rst), .a(a13), .b(b13), .ck(ck13), .acc_in(acc13_in), .acc_out(acc13_out));

  function automatic logic [19:0] acc_model(input logic [19:0] acc, input int c);
    logic [20:0] s;
    s = {1'b0, acc} + 21'(c * c);
`ifdef CK_SQACC_SATURATE_EN
    return s[20] ? 20'hFFFFF : s[19:0];
`else
    return s[19:0];
`endif
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a_, b_, input logic [19:0] acc_,
                         input logic [7:0] ck_, input logic [19:0] eacc_,
                         input logic [12:0] a2, b2, input logic [19:0] acc2,
                         input logic [7:0] ck2, input logic [19:0] eacc2);
    va8[i] = a_;  vb8[i] = b_;  vacc8[i] = acc_;  eck8[i] = ck_;  eacc8[i] = eacc_;
    va13[i] = a2; vb13[i] = b2; vacc13[i] = acc2; eck13[i] = ck2; eacc13[i] = eacc2;
  endtask

  // Iteration k runs just after edge k: inputs for vector k go in, acc_in for k-2 goes in,
  // ck of vector k-2 and acc_out of vector k-3 are checked.
  task automatic run_stream(input int n);
    for (int k = 0; k < n + 3; k++) begin
      if (k >= 2 && k - 2 < n) begin
        check("ck8",  k - 2, 32'(ck8),  32'(eck8[k-2]));
        check("ck13", k - 2, 32'(ck13), 32'(eck13[k-2]));
      end
      if (k >= 3) begin
        check("acc8",  k - 3, 32'(acc8_out),  32'(eacc8[k-3]));
        check("acc13", k - 3, 32'(acc13_out), 32'(eacc13[k-3]));
      end
      a8  = (k < n) ? va8[k]  : '0;
      b8  = (k < n) ? vb8[k]  : '0;
      a13 = (k < n) ? va13[k] : '0;
      b13 = (k < n) ? vb13[k] : '0;
      acc8_in  = (k >= 2 && k - 2 < n) ? vacc8[k-2]  : '0;
      acc13_in = (k >= 2 && k - 2 < n) ? vacc13[k-2] : '0;
      @(posedge clk); #1;
    end
  endtask

  logic [19:0] w8_a, w8_b, w13_a, w13_b;

  initial begin
`ifdef CK_SQACC_SATURATE_EN
    w8_a = 20'hFFFFF; w8_b = 20'hFFFFF; w13_a = 20'hFFFFF; w13_b = 20'hFFFFF;
`else
    w8_a = 20'h00003; w8_b = 20'h00000; w13_a = 20'h00000; w13_b = 20'h00019;
`endif
    //          a8     b8     acc8        ck8    eacc8     a13       b13       acc13       ck13   eacc13
    set_vec(0, 8'hFF, 8'hFF, 20'd0,       8'h08, 20'd64,   13'h0000, 13'h003F, 20'hFFFFF, 8'h01, w13_a);
    set_vec(1, 8'h00, 8'hFF, 20'd10,      8'hF8, 20'd74,   13'h1FFF, 13'h0000, 20'd3,     8'hF3, 20'd172);
    set_vec(2, 8'h0F, 8'h00, 20'd5,       8'h00, 20'd5,    13'h1555, 13'h1555, 20'd0,     8'h0D, 20'd169);
    set_vec(3, 8'h00, 8'h0D, 20'd100,     8'h02, 20'd104,  13'h0000, 13'h0001, 20'd50,    8'h0B, 20'd171);
    set_vec(4, 8'h00, 8'h07, 20'hFFFFF,   8'h02, w8_a,     13'h0FFF, 13'h0000, 20'hFFF00, 8'hF5, 20'hFFF79);
    set_vec(5, 8'h00, 8'h07, 20'hFFFFC,   8'h02, w8_b,     13'h1000, 13'h0000, 20'hFFFA0, 8'h0B, w13_b);
    set_vec(6, 8'hAA, 8'h55, 20'd7,       8'hF8, 20'd71,   13'h00FF, 13'h0F0F, 20'd100,   8'hFD, 20'd109);
    set_vec(7, 8'h00, 8'h07, 20'hFFFFB,   8'h02, 20'hFFFFF,13'h0000, 13'h0000, 20'd0,     8'h0D, 20'd169);
    for (int i = ND; i < NT; i++) begin
      int c8, c13;
      va8[i]  = 8'($urandom);  vb8[i]  = 8'($urandom);  vacc8[i]  = 20'($urandom);
      va13[i] = 13'($urandom); vb13[i] = 13'($urandom); vacc13[i] = 20'($urandom);
      c8  = 8  - 2 * $countones(va8[i] ^ vb8[i]);
      c13 = 13 - 2 * $countones(va13[i] ^ vb13[i]);
      eck8[i]  = 8'(c8);  eacc8[i]  = acc_model(vacc8[i], c8);
      eck13[i] = 8'(c13); eacc13[i] = acc_model(vacc13[i], c13);
    end

    // Held in reset with random inputs: everything reads zero.
    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); acc8_in = 20'($urandom);
      a13 = 13'($urandom); b13 = 13'($urandom); acc13_in = 20'($urandom);
      @(posedge clk); #1;
      check("rst_ck8", i, 32'(ck8), 32'h0);
      check("rst_acc8", i, 32'(acc8_out), 32'h0);
      check("rst_ck13", i, 32'(ck13), 32'h0);
      check("rst_acc13", i, 32'(acc13_out), 32'h0);
    end
    rst = 1'b1;

    run_stream(NT);

    // Fill the pipeline, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) begin
      a8 = 8'h00; b8 = 8'hFF; acc8_in = 20'd1000;
      a13 = 13'h1FFF; b13 = 13'h0000; acc13_in = 20'd1000;
      @(posedge clk); #1;
    end
    #3 rst = 1'b0;
    #1;
    check("arst_ck8", 0, 32'(ck8), 32'h0);
    check("arst_acc8", 0, 32'(acc8_out), 32'h0);
    check("arst_ck13", 0, 32'(ck13), 32'h0);
    check("arst_acc13", 0, 32'(acc13_out), 32'h0);
    @(posedge clk); #1;
    check("arst_hold_ck8", 1, 32'(ck8), 32'h0);
    check("arst_hold_acc13", 1, 32'(acc13_out), 32'h0);
    rst = 1'b1;

    run_stream(ND);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
